// File: rtl/onehot_decoder_buf.sv
// Binary code + tag decoded to a one-hot vector, buffered in a 2-entry skid FIFO.
// Optional per-code hit counters are built only when ONEHOT_DEC_CNT_EN is defined.

// Two-entry FIFO with 1-bit pointers and a 0..2 occupancy count.
// Latency: a pushed entry is visible at head_dat on the next cycle.
// Backpressure: full depends only on the stored count, never on a same-cycle pop.
module onehot_fifo2 #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the consumer gates it with the valid flag.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
endmodule

// Decodes code/tag to one-hot at enqueue and presents the head entry to the consumer.
// Latency: accepted at edge T into an empty buffer, visible at out from T+1.
// Backpressure: in_ready = not full (registered); a full buffer blocks even while popping.
module onehot_decoder_buf #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_code,
    input  logic               in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [(1<<W)-1:0]  out,
    output logic               out_tag,
    input  logic               cnt_clr,
    input  logic [W-1:0]       cnt_sel,
    output logic [CNT_W-1:0]   cnt_val
);
    localparam int N = 1 << W;

    typedef struct packed {
        logic [N-1:0] vec;
        logic         tag;
    } ent_t;

    ent_t wr_ent;
    ent_t rd_ent;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic hit;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign hit       = en && in_tag;

    // en=0 blanks the select but the producer's tag is still passed through.
    always_comb begin
        wr_ent     = '0;
        wr_ent.tag = in_tag;
        if (hit) wr_ent.vec = N'(1) << in_code;
    end

    onehot_fifo2 #(
        .DW ($bits(ent_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (wr_ent),
        .pop      (pop),
        .head_dat (rd_ent),
        .full     (full),
        .empty    (empty)
    );

    assign out     = out_valid ? rd_ent.vec : '0;
    assign out_tag = out_valid ? rd_ent.tag : 1'b0;

`ifdef ONEHOT_DEC_CNT_EN
    logic [CNT_W-1:0] cnt [N];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (push && hit && (cnt[in_code] != '1)) begin
            cnt[in_code] <= cnt[in_code] + 1'b1;
        end
    end

    assign cnt_val = cnt[cnt_sel];
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_clr, cnt_sel};
    assign cnt_val    = '0;
`endif
endmodule
